// File: rtl/paddle_pos_ctrl.sv
// rtl/paddle_pos_ctrl.sv - N-channel debounced, saturating paddle position controller.
// Optional acceleration (double step after ACCEL_TICKS same-direction ticks) under `PADDLE_ACCEL_EN.
module paddle_pos_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int POS_W       = 12,
  parameter int MIN_POS     = 0,
  parameter int MAX_POS     = 400,
  parameter int INIT_POS    = 200,
  parameter int STEP        = 4,
  parameter int DB_CYCLES   = 16,
  parameter int ACCEL_TICKS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [NUM_CH-1:0]       btn_up,
  input  logic [NUM_CH-1:0]       btn_dn,
  output logic [NUM_CH*POS_W-1:0] pos,
  output logic [NUM_CH-1:0]       at_top,
  output logic [NUM_CH-1:0]       at_bot,
  output logic [NUM_CH-1:0]       moving
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [POS_W:0]   MIN_W  = (POS_W+1)'(MIN_POS);
  localparam logic [POS_W:0]   MAX_W  = (POS_W+1)'(MAX_POS);
  localparam logic [POS_W:0]   STEP_W = (POS_W+1)'(STEP);
  localparam logic [POS_W-1:0] INIT_P = POS_W'(INIT_POS);
  localparam logic [DBW-1:0]   DB_LAST = DBW'(DB_CYCLES - 1);
`ifdef PADDLE_ACCEL_EN
  localparam int AW = $clog2(ACCEL_TICKS + 1);
  localparam logic [POS_W:0] FAST_W = (POS_W+1)'(2 * STEP);
`endif

  if (MAX_POS >= 2**POS_W || INIT_POS < MIN_POS || INIT_POS > MAX_POS ||
      STEP < 1 || DB_CYCLES < 1 || ACCEL_TICKS < 1 || NUM_CH < 1) begin : g_bad_params
    $error("paddle_pos_ctrl: illegal parameter set");
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [1:0]          raw, s1, s2, stable;   // bit 0 = up, bit 1 = down
    logic [1:0][DBW-1:0] cnt;
    logic [POS_W-1:0]    pos_r;
    logic [POS_W:0]      ext, nxt_w, step_w;
    logic                top_r, bot_r, mov_r, up, dn;

    assign raw = {btn_dn[ch], btn_up[ch]};
    assign up  = stable[0] & ~stable[1];
    assign dn  = stable[1] & ~stable[0];
    assign ext = {1'b0, pos_r};

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1     <= '0;
        s2     <= '0;
        stable <= '0;
        cnt    <= '0;
      end else begin
        s1 <= raw;
        s2 <= s1;
        for (int b = 0; b < 2; b++) begin
          if (s2[b] != stable[b]) begin
            if (cnt[b] == DB_LAST) begin
              stable[b] <= s2[b];
              cnt[b]    <= '0;
            end else begin
              cnt[b] <= cnt[b] + 1'b1;
            end
          end else begin
            cnt[b] <= '0;
          end
        end
      end
    end

`ifdef PADDLE_ACCEL_EN
    logic [AW-1:0] acc_cnt;
    logic          last_dn;

    // Counter tracks consecutive same-direction ticks; any hold or reversal restarts it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc_cnt <= '0;
        last_dn <= 1'b0;
      end else if (tick) begin
        if (up | dn) begin
          if (dn != last_dn) begin
            acc_cnt <= '0;
            last_dn <= dn;
          end else if (acc_cnt != AW'(ACCEL_TICKS)) begin
            acc_cnt <= acc_cnt + 1'b1;
          end
        end else begin
          acc_cnt <= '0;
        end
      end
    end

    assign step_w = (acc_cnt == AW'(ACCEL_TICKS)) ? FAST_W : STEP_W;
`else
    assign step_w = STEP_W;
`endif

    // Distances to the limits are taken in POS_W+1 bits so the clamp never wraps.
    always_comb begin
      nxt_w = ext;
      if (up) begin
        if (ext - MIN_W < step_w) nxt_w = MIN_W;
        else                      nxt_w = ext - step_w;
      end else if (dn) begin
        if (MAX_W - ext < step_w) nxt_w = MAX_W;
        else                      nxt_w = ext + step_w;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pos_r <= INIT_P;
        top_r <= (INIT_POS == MIN_POS);
        bot_r <= (INIT_POS == MAX_POS);
        mov_r <= 1'b0;
      end else if (tick) begin
        pos_r <= nxt_w[POS_W-1:0];
        top_r <= (nxt_w == MIN_W);
        bot_r <= (nxt_w == MAX_W);
        mov_r <= (nxt_w != ext);
      end else begin
        mov_r <= 1'b0;
      end
    end

    assign pos[ch*POS_W +: POS_W] = pos_r;
    assign at_top[ch] = top_r;
    assign at_bot[ch] = bot_r;
    assign moving[ch] = mov_r;
  end

endmodule
